// File: rtl/if_fetch_sched.sv
// rtl/if_fetch_sched.sv - dual-instruction fetch scheduler with cancel tracking and skid buffer (optional perf counters: IF_FETCH_PERF_CNT_EN)
module if_fetch_sched #(
    parameter int FETCH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        preif_valid_i,
    input  logic [31:0] preif_pc_i,
    output logic        preif_allowin_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [63:0] inst_rdata_i,
    input  logic        if_allowin_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [63:0] if_inst_o,
    input  logic        excep_flush_i,
    input  logic        banch_flush_i,
    output logic        inst_rdata_ce_o
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_req_cnt_o,
    output logic [31:0] perf_drop_cnt_o
`endif
);

    localparam logic [2:0] DEPTH = 3'(FETCH_DEPTH);

    typedef enum logic [1:0] {
        CLR0 = 2'd0,
        CLR1 = 2'd1,
        CLR2 = 2'd2
    } cancel_e;

    cancel_e          cancel_q, cancel_d;
    logic [1:0]       live_q, live_d;
    logic [1:0][31:0] fifo_q, fifo_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [63:0]      out_inst_q, out_inst_d;
    logic             skid_valid_q, skid_valid_d;
    logic [31:0]      skid_pc_q, skid_pc_d;
    logic [63:0]      skid_inst_q, skid_inst_d;
    logic             ce_q, ce_d;
    logic [31:0]      perf_req_q, perf_req_d;
    logic [31:0]      perf_drop_q, perf_drop_d;

    logic        flush;
    logic        held;
    logic        out_free;
    logic [2:0]  occ;
    logic [2:0]  outstanding;
    logic        accept;
    logic        resp;
    logic        resp_live;
    logic        resp_cancel;
    logic [31:0] head_pc;

    // Issue decision and response classification; a data_ok with nothing outstanding is ignored
    always_comb begin
        flush       = excep_flush_i | banch_flush_i;
        held        = out_valid_q & ~if_allowin_i;
        out_free    = ~out_valid_q | if_allowin_i;
        occ         = {1'b0, live_q} + {2'b0, skid_valid_q} + {2'b0, held};
        outstanding = {1'b0, live_q} + {1'b0, cancel_q};
        inst_req_o  = preif_valid_i & ~flush & (outstanding < DEPTH) & (occ < 3'd2);
        accept      = inst_req_o & inst_addr_ok_i;
        resp        = inst_data_ok_i & (outstanding != 3'd0);
        resp_cancel = resp & (cancel_q != CLR0);
        resp_live   = resp & (cancel_q == CLR0);
        head_pc     = fifo_q[rd_ptr_q];
    end

    // Next-state: flush overrides issue, routing and drain; otherwise push/pop/route/drain
    always_comb begin
        cancel_d     = cancel_q;
        live_d       = live_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        perf_req_d   = perf_req_q + {31'b0, accept};
        perf_drop_d  = perf_drop_q + {31'b0, resp_cancel | (resp & flush)};
        if (flush) begin
            // live requests become cancelled, minus whichever response lands this cycle
            cancel_d     = cancel_e'(outstanding[1:0] - {1'b0, resp});
            live_d       = 2'd0;
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            live_d = live_q + {1'b0, accept} - {1'b0, resp_live};
            if (resp_cancel) begin
                cancel_d = cancel_e'(cancel_q - 2'd1);
            end
            if (accept) begin
                fifo_d[wr_ptr_q] = preif_pc_i;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (resp_live) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_pc_d     = skid_pc_q;
                    out_inst_d   = skid_inst_q;
                    skid_valid_d = resp_live;
                    if (resp_live) begin
                        skid_pc_d   = head_pc;
                        skid_inst_d = inst_rdata_i;
                    end
                end else if (resp_live) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = head_pc;
                    out_inst_d  = inst_rdata_i;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (resp_live) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = head_pc;
                skid_inst_d  = inst_rdata_i;
            end
        end
        ce_d = (cancel_d != CLR0);
    end

    // State registers including the cancel FSM; asynchronous reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel_q     <= CLR0;
            live_q       <= 2'd0;
            fifo_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'd0;
            out_inst_q   <= 64'd0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_inst_q  <= 64'd0;
            ce_q         <= 1'b0;
            perf_req_q   <= 32'd0;
            perf_drop_q  <= 32'd0;
        end else begin
            cancel_q     <= cancel_d;
            live_q       <= live_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            ce_q         <= ce_d;
            perf_req_q   <= perf_req_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    // Output mapping
    always_comb begin
        preif_allowin_o = accept;
        inst_addr_o     = preif_pc_i;
        if_valid_o      = out_valid_q;
        if_pc_o         = out_pc_q;
        if_inst_o       = out_inst_q;
        inst_rdata_ce_o = ce_q;
    end

`ifdef IF_FETCH_PERF_CNT_EN
    assign perf_req_cnt_o  = perf_req_q;
    assign perf_drop_cnt_o = perf_drop_q;
`else
    logic perf_unused;
    assign perf_unused = ^{perf_req_q, perf_drop_q};
`endif

endmodule

// File: tb/tb_if_fetch_sched.sv
// tb/tb_if_fetch_sched.sv - scoreboard bench for if_fetch_sched
module tb_if_fetch_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        preif_valid_i;
    logic [31:0] preif_pc_i;
    logic        preif_allowin_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [63:0] inst_rdata_i;
    logic        if_allowin_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [63:0] if_inst_o;
    logic        excep_flush_i;
    logic        banch_flush_i;
    logic        inst_rdata_ce_o;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_req_cnt_o;
    logic [31:0] perf_drop_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] bus_q[$];
    logic [95:0] exp_q[$];
    int          tb_cancel = 0;
    int          acc_cnt   = 0;
    int          drop_cnt  = 0;

    if_fetch_sched #(.FETCH_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .preif_valid_i   (preif_valid_i),
        .preif_pc_i      (preif_pc_i),
        .preif_allowin_o (preif_allowin_o),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_addr_ok_i  (inst_addr_ok_i),
        .inst_data_ok_i  (inst_data_ok_i),
        .inst_rdata_i    (inst_rdata_i),
        .if_allowin_i    (if_allowin_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .excep_flush_i   (excep_flush_i),
        .banch_flush_i   (banch_flush_i),
        .inst_rdata_ce_o (inst_rdata_ce_o)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_req_cnt_o  (perf_req_cnt_o),
        .perf_drop_cnt_o (perf_drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop: a pair is consumed whenever IF is valid and allowed in
    always @(negedge clk) begin
        if (!rst && if_valid_o && if_allowin_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(if_valid_o), 64'd0);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("out_pc", 64'(if_pc_o), 64'(e[95:64]));
                check("out_inst", if_inst_o, e[63:0]);
            end
        end
    end

    // One bus cycle: drive inputs, check issue, update the reference model
    task automatic step(input logic pv, input logic [31:0] pc, input logic aok,
                        input logic dok, input logic [63:0] rdata, input logic allow,
                        input logic bfl, input logic efl, input logic exp_req);
        logic [31:0] p;
        check("cancel_ce", 64'(inst_rdata_ce_o), 64'(tb_cancel != 0));
        preif_valid_i  = pv;
        preif_pc_i     = pc;
        inst_addr_ok_i = aok;
        inst_data_ok_i = dok;
        inst_rdata_i   = rdata;
        if_allowin_i   = allow;
        banch_flush_i  = bfl;
        excep_flush_i  = efl;
        #1;
        check("inst_req", 64'(inst_req_o), 64'(exp_req));
        check("preif_allowin", 64'(preif_allowin_o), 64'(exp_req & aok));
        if (exp_req) check("inst_addr", 64'(inst_addr_o), 64'(pc));
        if (dok) begin
            if (tb_cancel > 0) begin
                tb_cancel--;
                drop_cnt++;
            end else if (bus_q.size() > 0) begin
                p = bus_q.pop_front();
                if (bfl | efl) drop_cnt++;
                else exp_q.push_back({p, rdata});
            end
        end
        if (bfl | efl) begin
            tb_cancel += bus_q.size();
            bus_q.delete();
            exp_q.delete();
        end else if (exp_req && aok) begin
            bus_q.push_back(pc);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic allow);
        step(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, allow, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        preif_valid_i = 0; preif_pc_i = 0; inst_addr_ok_i = 0; inst_data_ok_i = 0;
        inst_rdata_i = 0; if_allowin_i = 0; banch_flush_i = 0; excep_flush_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(if_valid_o), 64'd0);
        check("rst_pc", 64'(if_pc_o), 64'd0);
        check("rst_inst", if_inst_o, 64'd0);
        check("rst_ce", 64'(inst_rdata_ce_o), 64'd0);
        check("rst_req", 64'(inst_req_o), 64'd0);
        rst = 1'b0;

        // basic fetch: request N, data N+1, valid N+2
        step(1, 32'h1C00_0000, 1, 0, 64'd0, 1, 0, 0, 1);
        step(0, 32'd0, 0, 1, 64'h0000_0002_0000_0001, 1, 0, 0, 0);
        check("basic_valid", 64'(if_valid_o), 64'd1);
        idle(1);
        idle(1);

        // backpressure: out holds first, skid holds second, then in-order drain
        step(1, 32'h1C00_0010, 1, 0, 64'd0, 0, 0, 0, 1);
        step(1, 32'h1C00_0018, 1, 1, 64'hAAAA_0001_AAAA_0000, 0, 0, 0, 1);
        step(1, 32'h1C00_0020, 1, 1, 64'hBBBB_0001_BBBB_0000, 0, 0, 0, 0);
        step(1, 32'h1C00_0020, 1, 0, 64'd0, 0, 0, 0, 0);
        check("bp_valid", 64'(if_valid_o), 64'd1);
        idle(1);
        idle(1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        idle(1);

        // branch flush with two in flight, cap while cancel_cnt is 2, then two drops
        step(1, 32'h1C00_0100, 1, 0, 64'd0, 1, 0, 0, 1);
        step(1, 32'h1C00_0108, 1, 0, 64'd0, 1, 0, 0, 1);
        step(1, 32'h1C00_0110, 1, 0, 64'd0, 0, 1, 0, 0);
        step(1, 32'h1C00_0110, 1, 0, 64'd0, 1, 0, 0, 0);
        step(1, 32'h1C00_0110, 0, 1, 64'hDEAD_0000_DEAD_0001, 1, 0, 0, 0);
        step(0, 32'd0, 0, 1, 64'hDEAD_0000_DEAD_0002, 1, 0, 0, 0);
        check("flush2_valid", 64'(if_valid_o), 64'd0);
        idle(1);

        // flush coinciding with data_ok, one live: nothing left to cancel
        step(1, 32'h1C00_0200, 1, 0, 64'd0, 1, 0, 0, 1);
        step(0, 32'd0, 0, 1, 64'h1111_2222_3333_4444, 0, 1, 0, 0);
        check("flush1_valid", 64'(if_valid_o), 64'd0);
        idle(1);

        // flush coinciding with data_ok, two live: one left to cancel
        step(1, 32'h1C00_0300, 1, 0, 64'd0, 1, 0, 0, 1);
        step(1, 32'h1C00_0308, 1, 0, 64'd0, 1, 0, 0, 1);
        step(0, 32'd0, 0, 1, 64'h5555_6666_7777_8888, 0, 0, 1, 0);
        step(0, 32'd0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 1, 0, 0, 0);
        idle(1);

        // asynchronous reset between edges with a pair held and one request live
        step(1, 32'h1C00_0400, 1, 0, 64'd0, 1, 0, 0, 1);
        step(1, 32'h1C00_0408, 1, 1, 64'h0404_0404_0404_0404, 0, 0, 0, 1);
        check("pre_rst_valid", 64'(if_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        preif_valid_i = 0; inst_addr_ok_i = 0; inst_data_ok_i = 0;
        #1;
        check("arst_valid", 64'(if_valid_o), 64'd0);
        check("arst_pc", 64'(if_pc_o), 64'd0);
        check("arst_inst", if_inst_o, 64'd0);
        check("arst_ce", 64'(inst_rdata_ce_o), 64'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        check("arst_perf_req", 64'(perf_req_cnt_o), 64'd0);
        check("arst_perf_drop", 64'(perf_drop_cnt_o), 64'd0);
`endif
        bus_q.delete();
        exp_q.delete();
        tb_cancel = 0;
        acc_cnt = 0;
        drop_cnt = 0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fetch again after reset
        step(1, 32'h1C00_0500, 1, 0, 64'd0, 1, 0, 0, 1);
        step(0, 32'd0, 0, 1, 64'hCAFE_F00D_1234_5678, 1, 0, 0, 0);
        idle(1);
        idle(1);
        check("final_drained", 64'(exp_q.size()), 64'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        check("perf_req", 64'(perf_req_cnt_o), 64'(acc_cnt));
        check("perf_drop", 64'(perf_drop_cnt_o), 64'(drop_cnt));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_sched.md
# if_fetch_sched

Fetch-request scheduler between the pre-IF PC generator and the IF stage register. It issues dual-instruction fetch requests on the SRAM-like instruction bus and keeps at most two requests in flight. It holds returned instruction pairs in an IF output register backed by a one-entry skid buffer. On exception or branch flush it discards responses that are still in flight, tracking them with a cancel counter.

## Interface
- `FETCH_DEPTH`, default 2: maximum outstanding bus requests (live plus cancelled). Only the value 2 is supported.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `preif_valid_i` in 1: the pre-IF stage holds a valid fetch PC.
- `preif_pc_i` in 32: fetch address of the instruction pair. Bits [2:0] are zero.
- `preif_allowin_o` out 1: PC accepted this cycle (the bus request handshake completes).
- `inst_req_o` out 1: bus request.
- `inst_addr_o` out 32: bus address. Equals `preif_pc_i`.
- `inst_addr_ok_i` in 1: bus accepted the address.
- `inst_data_ok_i` in 1: bus returns data. Returns are strictly in order.
- `inst_rdata_i` in 64: returned pair, {inst2, inst1}.
- `if_allowin_i` in 1: IF consumes the output register this cycle if it is valid.
- `if_valid_o` out 1: output register valid.
- `if_pc_o` out 32: PC of the held pair.
- `if_inst_o` out 64: held pair.
- `excep_flush_i` in 1: exception flush.
- `banch_flush_i` in 1: branch flush.
- `inst_rdata_ce_o` out 1: high while the cancel counter is non-zero.
- `perf_req_cnt_o` out 32: accepted requests. Present only with the macro.
- `perf_drop_cnt_o` out 32: discarded responses. Present only with the macro.

## Operation
- **State:**
  - 2-entry PC FIFO for live outstanding requests (`live_cnt` 0..2).
  - `cancel_cnt` 0..2.
  - Output register: valid, pc, inst.
  - Skid register: valid, pc, inst.
- **Definitions:**
  - `flush` = `excep_flush_i | banch_flush_i`.
  - `occ` = `live_cnt` + `skid_valid` + (`if_valid_o & ~if_allowin_i`).
- **Issue:** `inst_req_o` = `preif_valid_i & ~flush & (live_cnt+cancel_cnt < 2) & (occ < 2)`.
  - Acceptance occurs when `inst_req_o & inst_addr_ok_i`. The PC is pushed into the FIFO and `preif_allowin_o` is asserted.
- **Response:** on `inst_data_ok_i`:
  - If `cancel_cnt > 0`: decrement it and drop the data.
  - Otherwise pop the FIFO head PC and route the pair:
    - To the output register if it is empty or being consumed and the skid is empty.
    - Otherwise to the skid.
  - `inst_data_ok_i` with `live_cnt = cancel_cnt = 0` is a bus protocol error. Ignore it.
- **Drain:** when the output register is empty or consumed and the skid is valid, move the skid into the output register. A simultaneous new response goes into the skid.
- **Flush cycle:**
  - `if_valid_o` and `skid_valid` clear.
  - `cancel_cnt` <= `cancel_cnt + live_cnt - (data_ok & cancel_cnt==0 ? 1 : 0) - (data_ok & cancel_cnt>0 ? 1 : 0)`.
  - `live_cnt` <= 0 and the FIFO is emptied.
  - No request is issued.
- **Cancel FSM** (encoding follows `cancel_cnt`): CLR0 → CLR1 → CLR2.
  - Flush adds live requests.
  - Each dropped response steps down one state.
  - CLR2 stays in CLR2 on flush, because the sum is bounded by 2.
- **Reset values:** all counters 0, FIFO empty, `if_valid_o` 0, `if_pc_o` 0, `if_inst_o` 0, skid empty, `inst_rdata_ce_o` 0, perf counters 0.

## Timing
- `inst_req_o`, `inst_addr_o` and `preif_allowin_o` are combinational from the inputs and state. There is no cycle of latency from valid to request.
- A response on cycle N reaches `if_valid_o` at the N+1 edge when there is room. The minimum PC-to-`if_valid_o` latency is 2 cycles (addr_ok at N, data_ok at N+1, valid at N+2).
- Flush has priority over every simultaneous event: issue, response routing and drain.
- A response arriving in the flush cycle is always dropped. If it was live, it is not counted into `cancel_cnt`.
- Reset asserted mid-transaction clears all state immediately. The bus must also be reset.

## Configuration
- `IF_FETCH_PERF_CNT_EN`:
  - **Defined:** `perf_req_cnt_o` increments on each accepted request and `perf_drop_cnt_o` increments on each dropped response. Both are 32-bit and wrap at 2^32.
  - **Undefined:** both ports and counters are absent. Function is otherwise identical.

## Test plan
- **Basic fetch:** PC 0x1C000000, `addr_ok` immediate, `data_ok` next cycle with 0x0000_0002_0000_0001 → `if_valid_o`=1, `if_pc_o`=0x1C000000, `if_inst_o`=0x0000000200000001 two cycles after the request.
- **Backpressure:** `if_allowin_i`=0 with two responses → output register holds the first, skid holds the second, `inst_req_o`=0. Releasing `if_allowin_i` → in-order delivery on consecutive cycles.
- **Flush with two in flight:** `banch_flush_i` pulse → `inst_rdata_ce_o`=1 and `cancel_cnt`=2. The next two `data_ok`s are dropped with `if_valid_o` staying 0, then `inst_rdata_ce_o`=0.
- **Flush coinciding with data_ok:**
  - One live request and `data_ok` in the flush cycle → `cancel_cnt`=0 afterwards and the data is dropped.
  - Two live requests → `cancel_cnt`=1.
- **Cap:** `cancel_cnt`=2 → `inst_req_o` stays 0 until a drop occurs, even with `preif_valid_i`=1.
- **Async reset mid-flight:** assert `rst` between clock edges → all outputs 0 immediately. With the macro defined, perf counters read 0.
